// File: rtl/program_sequencer_pkg.sv
// Shared types and instruction-word field layout for the MC14500B-style sequencer.
// Instruction word: opcode in the top OPCODE_W bits, operand in the low SIZE_LOG bits.
package mc14500_pkg;

    localparam int unsigned OPCODE_W    = 4;
    localparam int unsigned OPERAND_LSB = 0;

    typedef enum logic [OPCODE_W-1:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } seq_state_t;

    // The opcode field starts directly above the operand field.
    function automatic int unsigned opcode_lsb(input int unsigned size_log);
        return size_log + OPERAND_LSB;
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Program-memory fetch bus: the sequencer is master, the instruction memory is slave.
interface program_sequencer_if
    import mc14500_pkg::*;
#(
    parameter int unsigned SIZE_LOG = 12
) ();

    logic                         mem_req;
    logic [SIZE_LOG-1:0]          mem_addr;
    logic                         mem_valid;
    logic [OPCODE_W+SIZE_LOG-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_valid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_valid,
        output mem_rdata
    );

endinterface

// File: rtl/program_sequencer_return_stack.sv
// LIFO of return addresses; pushes on full and pops on empty are ignored here,
// the sequencer decides how to report them.
module return_stack #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] top_idx;

    // DEPTH is a power of two, so the low pointer bits wrap naturally.
    assign wr_idx  = count[PTR_W-1:0];
    assign top_idx = wr_idx - 1'b1;
    assign dout    = mem[top_idx];
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[wr_idx] <= din;
            count       <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Instruction sequencer: owns pc, fetches over the memory bus, decodes control flow
// and strobes every executed instruction to the logic unit.
module program_sequencer
    import mc14500_pkg::*;
#(
    parameter int unsigned SIZE_LOG     = 12,
    parameter int unsigned STACK_DEPTH  = 4,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    program_sequencer_if.master   bus,
    input  logic                  rr,
    output logic                  exec_valid,
    output logic [OPCODE_W-1:0]   exec_opcode,
    output logic [SIZE_LOG-1:0]   exec_operand,
    output logic                  flag_o,
    output logic                  flag_f,
    output logic                  jmp_o,
    output logic                  rtn_o,
    output logic [SIZE_LOG-1:0]   pc,
    output logic                  busy,
    output logic                  stack_err
);

    localparam int unsigned OPC_LSB = opcode_lsb(SIZE_LOG);

    seq_state_t                   state, state_d;
    logic [SIZE_LOG-1:0]          pc_d, pc_inc;
    logic [OPCODE_W+SIZE_LOG-1:0] ir, ir_d;
    logic                         skip_pending, skip_d;
    logic                         err_set;
    logic                         push, pop, stk_full, stk_empty;
    logic [SIZE_LOG-1:0]          stk_dout;
    opcode_t                      op;
    logic                         exec_active;

    assign op           = opcode_t'(ir[OPC_LSB +: OPCODE_W]);
    assign exec_opcode  = ir[OPC_LSB +: OPCODE_W];
    assign exec_operand = ir[OPERAND_LSB +: SIZE_LOG];
    assign pc_inc       = pc + 1'b1;

    // Strobes decode only registered state/ir, so they are clean for the whole EXEC cycle.
    assign exec_active  = (state == EXEC) && !skip_pending;
    assign exec_valid   = exec_active;
    assign flag_o       = exec_active && (op == NOPO);
    assign flag_f       = exec_active && (op == NOPF);
    assign jmp_o        = exec_active && (op == JMP);
    assign rtn_o        = exec_active && (op == RTN);
    assign busy         = (state != IDLE);
    assign bus.mem_req  = (state == FETCH);
    assign bus.mem_addr = pc;

    return_stack #(
        .WIDTH (SIZE_LOG),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= SIZE_LOG'(RESET_VECTOR);
            ir           <= '0;
            skip_pending <= 1'b0;
            stack_err    <= 1'b0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            ir           <= ir_d;
            skip_pending <= skip_d;
            if (err_set) stack_err <= 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        ir_d    = ir;
        skip_d  = skip_pending;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (bus.mem_valid) begin
                    ir_d    = bus.mem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = run ? FETCH : IDLE;
                pc_d    = pc_inc;
                if (skip_pending) begin
                    skip_d = 1'b0;
                end else begin
                    case (op)
                        JMP: begin
                            push    = 1'b1;
                            err_set = stk_full;
                            pc_d    = exec_operand;
                        end
                        RTN: begin
                            if (stk_empty) begin
                                err_set = 1'b1;
                            end else begin
                                pop  = 1'b1;
                                pc_d = stk_dout;
                            end
                        end
                        SKZ: begin
                            if (!rr) skip_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
